spi_mem_loader: RTL
===================

Name: spi_mem_loader

Overview:
- SPI-mode-0 slave front end that turns a serial byte stream into byte writes for the 320x8 weight/delay memory.
- Drives the memory's `data_in`, `addr` and `write_enable` inputs directly.
- Address auto-increments, so a host can load all 320 bytes in one chip-select frame.
- Everything runs in the `clk` domain; SPI pins are oversampled.

Parameters:
- MEM_DEPTH, 320, number of addressable bytes; the address wraps at this value.
- ADDR_W, 9, width of `mem_addr`; must satisfy 2^ADDR_W >= MEM_DEPTH.
- SYNC_STAGES, 2, synchroniser flops on `sclk`, `cs_n` and `mosi`.

Ports:
- clk  in  1  system clock; must be at least 4x the `sclk` frequency.
- reset  in  1  asynchronous, active-high.
- sclk  in  1  SPI clock, asynchronous to `clk`, idles low.
- cs_n  in  1  SPI chip select, active-low.
- mosi  in  1  SPI data, MSB first, sampled on `sclk` rising edge.
- mem_data  out  8  byte to write.
- mem_addr  out  ADDR_W  write address.
- mem_we  out  1  one-`clk` write strobe.
- busy  out  1  high while a frame is in progress.
- frame_err  out  1  sticky flag; cleared only by reset.
- checksum  out  8  running XOR of data bytes (see Optional Feature).

Behaviour:
- Reset values: `mem_data` = 0, `mem_addr` = 0, `mem_we` = 0, `busy` = 0, `frame_err` = 0, `checksum` = 0. State = IDLE; bit counter and shift register cleared.
- Input synchronisation: each SPI input passes through SYNC_STAGES flops.
  - `sclk` rise is detected from the last two synchronised samples.
  - Each detected rise shifts synchronised `mosi` into an 8-bit shift register, MSB first.
  - A bit counter (3 bits) flags byte completion on the 8th rise.
- Frame format, while `cs_n` is low:
  - Byte 0 = header. Bit7 is the write flag; bits6:1 are reserved and must be 0; bit0 = start address bit 8.
  - Byte 1 = start address bits 7:0.
  - Bytes 2..N = data.
- States:
  - IDLE: on synchronised `cs_n` falling, go to HDR and set `busy` = 1.
  - HDR: on byte complete, if bit7 = 1 and bits6:1 = 0, latch addr[8], go to ADDR. Otherwise set `frame_err` and go to DRAIN.
  - ADDR: on byte complete, form {hdr[0], byte}. If the value is >= MEM_DEPTH, set `frame_err` and go to DRAIN. Otherwise load the address counter and go to DATA.
  - DATA: on byte complete, in the following `clk` cycle drive `mem_data` = byte, `mem_addr` = counter, `mem_we` = 1 for exactly one cycle. Then increment the counter; MEM_DEPTH-1 wraps to 0. Remain in DATA.
  - DRAIN: ignore all bits until `cs_n` rises.
- Latency: `mem_we` asserts 1 `clk` after the `clk` edge that samples the 8th synchronised `sclk` rise.
- `mem_addr` and `mem_data` hold their values after the strobe until the next write.
- `cs_n` rising in any state:
  - Return to IDLE and set `busy` = 0.
  - Discard any partial byte (no write, no error).
  - Clear the bit counter.
- `cs_n` rising in the same cycle as a byte completion: the completion takes priority. The write is issued, then the block goes to IDLE.
- `cs_n` falling while `busy`: cannot occur without a rise first, so no special handling.
- Reset mid-frame: immediate return to reset values. The next frame is accepted only after a fresh `cs_n` fall.
- Unlimited data bytes per frame; the address keeps wrapping.

Optional Feature:
- Macro: SPI_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - `checksum` clears to 0 on each `cs_n` fall.
  - `checksum` XORs in every data byte in the same cycle as its `mem_we`.
  - `checksum` holds after the frame ends so the host can compare it.
- Undefined:
  - `checksum` is tied to 0.
  - No accumulator register is synthesised.
  - The port still exists.

Decomposition:
- Shared package `snn_mem_pkg`:
  - constants MEM_DEPTH = 320, ADDR_W = 9;
  - header bit positions HDR_WR_BIT = 7, HDR_A8_BIT = 0;
  - state enum {IDLE, HDR, ADDR, DATA, DRAIN}.
- One sub-module, `spi_sync_edge`: synchroniser plus `sclk` rise and `cs_n` fall/rise detection.
- Shift register, bit counter and FSM stay in the top module.

Test Plan:
- Write burst: header 0x80, address 0x05, data 0x11 0x22 0x33 -> three `mem_we` pulses at addresses 5, 6, 7 with data 0x11, 0x22, 0x33. `busy` falls on `cs_n` rise; `checksum` = 0x00 with the macro defined.
- Wrap: header 0x81, address 0x3E (addr 318), data 0xA0 0xA1 0xA2 0xA3 -> writes at 318, 319, 0, 1. `frame_err` = 0.
- Bad frames:
  - header 0x00 -> `frame_err` = 1, no writes;
  - after reset, header 0x81 with address 0x40 (addr 320) -> `frame_err` = 1, subsequent data bytes produce no `mem_we`.
- Abort: header 0x80, address 0x00, 1 full data byte 0x5A, then 5 bits, then `cs_n` high -> exactly one write (addr 0, 0x5A), no error. The next frame starts cleanly.
- Reset mid-frame: assert reset after 4 bits of the address byte -> all outputs 0 within the reset cycle. A new frame (0x80, 0x02, 0x77) writes 0x77 at addr 2.
- Checksum, with the macro defined: data 0x0F 0xF0 0xFF -> `checksum` = 0x00. Data 0x12 0x34 -> `checksum` = 0x26.

Source files
------------

// File: rtl/snn_mem_pkg.sv
// Shared constants and FSM state type for the SNN weight/delay memory loader.
package snn_mem_pkg;

  localparam int MEM_DEPTH = 320;
  localparam int ADDR_W    = 9;

  localparam int         HDR_WR_BIT    = 7;
  localparam int         HDR_A8_BIT    = 0;
  localparam logic [7:0] HDR_RSVD_MASK = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ADDR,
    DATA,
    DRAIN
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises the SPI pins into the clk domain and detects sclk rise and cs_n edges.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  // cs_n history resets to "asserted" so a chip select still held low when
  // reset releases is not mistaken for a new frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that streams bytes into the 320x8 weight/delay memory.
// Optional running XOR checksum enabled by SPI_MEM_LOADER_CHECKSUM_EN.
module spi_mem_loader
  import snn_mem_pkg::*;
#(
  parameter int MEM_DEPTH   = snn_mem_pkg::MEM_DEPTH,
  parameter int ADDR_W      = snn_mem_pkg::ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic sclk_rise, cs_fall, cs_rise, mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  state_t            state, state_next;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              a8_q;
  logic [8:0]        start_addr;
  logic [ADDR_W-1:0] addr_cnt;
  logic              latch_a8, load_addr, do_write, set_err;

  assign rx_byte    = {shift_q[6:0], mosi_s};
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign start_addr = {a8_q, rx_byte};
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_next = state;
    latch_a8   = 1'b0;
    load_addr  = 1'b0;
    do_write   = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      IDLE: if (cs_fall) state_next = HDR;
      HDR: begin
        if (byte_done) begin
          if (rx_byte[HDR_WR_BIT] && ((rx_byte & HDR_RSVD_MASK) == 8'h00)) begin
            latch_a8   = 1'b1;
            state_next = ADDR;
          end else begin
            set_err    = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      ADDR: begin
        if (byte_done) begin
          if (int'(start_addr) >= MEM_DEPTH) begin
            set_err    = 1'b1;
            state_next = DRAIN;
          end else begin
            load_addr  = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA:    if (byte_done) do_write = 1'b1;
      DRAIN:   ;
      default: state_next = IDLE;
    endcase
    // A byte completing with the cs_n rise still takes effect above.
    if (cs_rise) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE || cs_rise) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift_q <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a8_q      <= 1'b0;
      addr_cnt  <= '0;
      mem_data  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we <= do_write;
      if (latch_a8) a8_q <= rx_byte[HDR_A8_BIT];
      if (load_addr)
        addr_cnt <= ADDR_W'(start_addr);
      else if (do_write)
        addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
      if (do_write) begin
        mem_data <= rx_byte;
        mem_addr <= addr_cnt;
      end
      if (set_err) frame_err <= 1'b1;
    end
  end

`ifdef SPI_MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         csum_q <= '0;
    else if (cs_fall)  csum_q <= '0;
    else if (do_write) csum_q <= csum_q ^ rx_byte;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
